// File: rtl/ws2812_pkg.sv
// Shared state type, ns-to-cycle conversion and elaboration-time checks for the
// WS2812/SK6812 chain driver.
`ifndef WS2812_PKG_MACROS
`define WS2812_PKG_MACROS
`define WS2812_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end
`endif

package ws2812_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StLatch} state_e;

  function automatic int unsigned ns_to_cycles(input int unsigned clk_mhz,
                                               input int unsigned ns);
    return (clk_mhz * ns + 999) / 1000;
  endfunction

endpackage

// File: rtl/ws2812_bright_scale.sv
// Combinational global-brightness scaler: each byte lane becomes (c * (b + 1)) >> 8,
// so 255 is identity and 0 blanks the pixel.
module ws2812_bright_scale #(
  parameter int unsigned BITS_PER_LED = 24
) (
  input  logic [BITS_PER_LED-1:0] pix_i,
  input  logic [7:0]              bright_i,
  output logic [BITS_PER_LED-1:0] pix_o
);

  localparam int unsigned Lanes = BITS_PER_LED / 8;

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    assign pix_o[8*i +: 8] = 8'(({8'd0, pix_i[8*i +: 8]} * ({8'd0, bright_i} + 16'd1)) >> 8);
  end

endmodule

// File: rtl/ws2812_chain_driver.sv
// Single-pin WS2812/SK6812 chain driver: pixel RAM, brightness scaling, bit-timed
// serialiser and latch gap, either free-running or one frame per start pulse.
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned CLK_MHZ      = 12,
  parameter int unsigned T0H_NS       = 350,
  parameter int unsigned T1H_NS       = 900,
  parameter int unsigned PERIOD_NS    = 1250,
  parameter int unsigned RESET_US     = 280,
  parameter bit          CONTINUOUS   = 1'b1,
  localparam int unsigned ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [BITS_PER_LED-1:0] wr_data_i,
  input  logic [7:0]              brightness_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    data_o
);

  localparam int unsigned TPer = ns_to_cycles(CLK_MHZ, PERIOD_NS);
  localparam int unsigned T1h  = ns_to_cycles(CLK_MHZ, T1H_NS);
  localparam int unsigned T0h  = ns_to_cycles(CLK_MHZ, T0H_NS);
  localparam int unsigned TRst = CLK_MHZ * RESET_US;
  localparam int unsigned TMax = (TRst > TPer) ? TRst : TPer;
  localparam int unsigned CntW = $clog2(TMax + 1);
  localparam int unsigned BitW = $clog2(BITS_PER_LED);

  `WS2812_CHECK(g_bad_width, (BITS_PER_LED == 24) || (BITS_PER_LED == 32),
                "BITS_PER_LED must be 24 or 32")
  `WS2812_CHECK(g_bad_timing, (T0h < T1h) && (T1h < TPer), "need T0H < T1H < T_PER")
  `WS2812_CHECK(g_bad_count, NUM_LEDS >= 1, "NUM_LEDS must be at least 1")

  localparam logic [CntW-1:0]   PerLast   = CntW'(TPer - 1);
  localparam logic [CntW-1:0]   RstLast   = CntW'(TRst - 1);
  localparam logic [CntW-1:0]   T1hC      = CntW'(T1h);
  localparam logic [CntW-1:0]   T0hC      = CntW'(T0h);
  localparam logic [BitW-1:0]   BitLast   = BitW'(BITS_PER_LED - 1);
  localparam logic [ADDR_W-1:0] LedLast   = ADDR_W'(NUM_LEDS - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [ADDR_W-1:0]       led_q, led_d, rd_addr;
  logic [BITS_PER_LED-1:0] mem_q [NUM_LEDS];
  logic [BITS_PER_LED-1:0] rd_data_q, scaled, scaled_q, sr_q, sr_d;
  logic [7:0]              bright_q, bright_d;
  logic                    busy_q, busy_d, data_q, data_d;
  logic                    last_cyc, last_bit, last_led, fetch_last, latch_last;

  assign last_cyc   = cnt_q == PerLast;
  assign last_bit   = bit_q == BitLast;
  assign last_led   = led_q == LedLast;
  assign fetch_last = cnt_q == CntW'(1);
  assign latch_last = cnt_q == RstLast;

  // Outside SEND the read port parks on LED 0 so FETCH finds it ready.
  assign rd_addr = ((state_q == StSend) && !last_led) ? led_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (wr_en_i && (32'(wr_addr_i) < NUM_LEDS)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr];
    scaled_q  <= scaled;
  end

  ws2812_bright_scale #(
    .BITS_PER_LED(BITS_PER_LED)
  ) u_scale (
    .pix_i   (rd_data_q),
    .bright_i(bright_q),
    .pix_o   (scaled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CONTINUOUS ? StLatch : StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      led_q    <= '0;
      sr_q     <= '0;
      bright_q <= '0;
      busy_q   <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      led_q    <= led_d;
      sr_q     <= sr_d;
      bright_q <= bright_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StFetch;
      StFetch: if (fetch_last) state_d = StSend;
      StSend:  if (last_cyc && last_bit && last_led) state_d = StLatch;
      StLatch: if (latch_last) state_d = CONTINUOUS ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin : datapath
    cnt_d    = '0;
    bit_d    = '0;
    led_d    = '0;
    sr_d     = sr_q;
    bright_d = bright_q;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: if (start_i) busy_d = 1'b1;
      StFetch: begin
        cnt_d = fetch_last ? '0 : cnt_q + 1'b1;
        if (fetch_last) sr_d = scaled;
        else            bright_d = brightness_i;
      end
      StSend: begin
        cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        led_d = led_q;
        if (last_cyc) begin
          bit_d = last_bit ? '0 : bit_q + 1'b1;
          sr_d  = last_bit ? scaled_q : sr_q << 1;
          if (last_bit && !last_led) led_d = led_q + 1'b1;
        end
      end
      StLatch: begin
        cnt_d = latch_last ? '0 : cnt_q + 1'b1;
        if (latch_last) busy_d = CONTINUOUS;
      end
      default: ;
    endcase
    // Look one cycle ahead so the registered pin lines up with the SEND state.
    data_d = (state_d == StSend) && (cnt_d < (sr_d[BITS_PER_LED-1] ? T1hC : T0hC));
  end

  always_comb begin : outputs
    frame_done_o = (state_q == StLatch) && latch_last;
    busy_o       = busy_q;
    data_o       = data_q;
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Self-checking bench: three driver configurations checked cycle by cycle against a
// frame-level waveform model built from pixel words, brightness and bit timing.
module tb_ws2812_chain_driver;

  localparam int TPER = (12 * 1250 + 999) / 1000;
  localparam int T1H  = (12 * 900 + 999) / 1000;
  localparam int T0H  = (12 * 350 + 999) / 1000;
  localparam int TRST = 12 * 280;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  wr_en_v, start_v, busy_w, done_w, data_w;
  logic [1:0]  wr_addr_v;
  logic [31:0] wr_data_v;
  logic [7:0]  brightness_v;

  ws2812_chain_driver #(.NUM_LEDS(2), .BITS_PER_LED(24), .CONTINUOUS(1'b0)) u_a (
    .clk(clk), .reset(reset), .wr_en_i(wr_en_v[0]), .wr_addr_i(wr_addr_v[0:0]),
    .wr_data_i(wr_data_v[23:0]), .brightness_i(brightness_v), .start_i(start_v[0]),
    .busy_o(busy_w[0]), .frame_done_o(done_w[0]), .data_o(data_w[0]));

  ws2812_chain_driver #(.NUM_LEDS(3), .BITS_PER_LED(32), .CONTINUOUS(1'b0)) u_b (
    .clk(clk), .reset(reset), .wr_en_i(wr_en_v[1]), .wr_addr_i(wr_addr_v),
    .wr_data_i(wr_data_v), .brightness_i(brightness_v), .start_i(start_v[1]),
    .busy_o(busy_w[1]), .frame_done_o(done_w[1]), .data_o(data_w[1]));

  ws2812_chain_driver #(.NUM_LEDS(3), .BITS_PER_LED(24), .CONTINUOUS(1'b1)) u_c (
    .clk(clk), .reset(reset), .wr_en_i(wr_en_v[2]), .wr_addr_i(wr_addr_v),
    .wr_data_i(wr_data_v[23:0]), .brightness_i(brightness_v), .start_i(start_v[2]),
    .busy_o(busy_w[2]), .frame_done_o(done_w[2]), .data_o(data_w[2]));

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] mdl [3][4];
  int          hi_cnt [96];
  int          act_wr_k, act_wr_addr, act_start_k;
  logic [31:0] act_wr_val;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nleds_of(input int s);
    return (s == 0) ? 2 : 3;
  endfunction

  function automatic int bits_of(input int s);
    return (s == 1) ? 32 : 24;
  endfunction

  function automatic logic [31:0] scale_word(input logic [31:0] w, input int nb, input int b);
    logic [31:0] r = 0;
    for (int i = 0; i < nb / 8; i++) begin
      int c = int'(w[8*i +: 8]);
      r[8*i +: 8] = 8'((c * (b + 1)) / 256);
    end
    return r;
  endfunction

  // Expected pin level k cycles into SEND, from pixel words alone.
  function automatic logic exp_data(input logic [31:0] w [4], input int nb, input int b,
                                    input int k);
    int          led  = k / (nb * TPER);
    int          bitn = (k / TPER) % nb;
    int          ph   = k % TPER;
    logic [31:0] s    = scale_word(w[led], nb, b);
    logic        v    = s[nb - 1 - bitn];
    return ph < (v ? T1H : T0H);
  endfunction

  task automatic write_px(input int s, input int addr, input logic [31:0] val);
    wr_en_v[s] = 1'b1;
    wr_addr_v  = addr[1:0];
    wr_data_v  = val;
    step();
    wr_en_v[s] = 1'b0;
    if (addr < nleds_of(s)) mdl[s][addr] = val;
  endtask

  // Entered at the first FETCH cycle; returns at the frame_done cycle.
  task automatic expect_frame(input int s);
    int          nb, nbt, b;
    logic [31:0] w [4];
    nb  = bits_of(s);
    nbt = nleds_of(s) * nb * TPER;
    b   = int'(brightness_v);
    for (int i = 0; i < 4; i++) w[i] = mdl[s][i];
    for (int i = 0; i < 96; i++) hi_cnt[i] = 0;
    check("fetch busy", busy_w[s], 1);
    check("fetch data", data_w[s], 0);
    step();
    check("fetch2 data", data_w[s], 0);
    for (int k = 0; k < nbt; k++) begin
      step();
      check("send data", data_w[s], int'(exp_data(w, nb, b, k)));
      check("send done", done_w[s], 0);
      if (data_w[s]) hi_cnt[k / TPER]++;
      wr_en_v[s] = (k == act_wr_k);
      start_v[s] = (k == act_start_k);
      if (k == act_wr_k) begin
        wr_addr_v = act_wr_addr[1:0];
        wr_data_v = act_wr_val;
        if (act_wr_addr < nleds_of(s)) mdl[s][act_wr_addr] = act_wr_val;
      end
      if (k == 20) brightness_v = 8'($urandom);
    end
    wr_en_v[s] = 1'b0;
    start_v[s] = 1'b0;
    for (int j = 0; j < TRST; j++) begin
      step();
      check("latch data", data_w[s], 0);
      check("latch done", done_w[s], int'(j == TRST - 1));
    end
    check("busy at done", busy_w[s], 1);
    act_wr_k    = -1;
    act_start_k = -1;
  endtask

  task automatic run_single(input int s);
    start_v[s] = 1'b1;
    step();
    start_v[s] = 1'b0;
    expect_frame(s);
    step();
    check("idle busy", busy_w[s], 0);
    check("idle done", done_w[s], 0);
  endtask

  initial begin
    int ones, bad, waited;
    reset        = 1'b1;
    wr_en_v      = '0;
    start_v      = '0;
    wr_addr_v    = '0;
    wr_data_v    = '0;
    brightness_v = 8'd255;
    act_wr_k     = -1;
    act_wr_addr  = 0;
    act_wr_val   = '0;
    act_start_k  = -1;
    repeat (3) step();
    for (int s = 0; s < 3; s++) begin
      check("reset busy", busy_w[s], 0);
      check("reset data", data_w[s], 0);
      check("reset done", done_w[s], 0);
    end
    reset = 1'b0;

    // Full-scale frame: 8 ones, 39 zeros, final one.
    write_px(0, 0, 32'hFF0000);
    write_px(0, 1, 32'h000001);
    brightness_v = 8'd255;
    run_single(0);
    check("f1 bit0 high", hi_cnt[0], 11);
    check("f1 bit7 high", hi_cnt[7], 11);
    check("f1 bit8 high", hi_cnt[8], 5);
    check("f1 bit46 high", hi_cnt[46], 5);
    check("f1 bit47 high", hi_cnt[47], 11);

    // Half brightness: 0x80 bytes go out as 0x40.
    write_px(0, 0, 32'h808080);
    write_px(0, 1, $urandom);
    brightness_v = 8'd127;
    run_single(0);
    check("half bit0 high", hi_cnt[0], 5);
    check("half bit1 high", hi_cnt[1], 11);
    check("half bit2 high", hi_cnt[2], 5);
    check("half bit9 high", hi_cnt[9], 11);
    check("half bit17 high", hi_cnt[17], 11);

    write_px(0, 0, $urandom);
    write_px(0, 1, $urandom);
    brightness_v = 8'd0;
    run_single(0);
    ones = 0;
    for (int i = 0; i < 48; i++) if (hi_cnt[i] != 5) ones++;
    check("blank frame non-zero bits", ones, 0);

    // Start while busy must not queue a second frame.
    write_px(0, 0, $urandom);
    write_px(0, 1, $urandom);
    act_start_k = 100;
    run_single(0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy_w[0] || done_w[0]) bad++;
    end
    check("start during busy ignored", bad, 0);
    run_single(0);

    // Reset in the middle of bit 10 of LED 0.
    write_px(0, 0, $urandom);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step();
    for (int k = 0; k <= 10 * TPER; k++) step();
    check("abort pre data", data_w[0], 1);
    check("abort pre busy", busy_w[0], 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort data", data_w[0], 0);
    check("abort busy", busy_w[0], 0);
    check("abort done", done_w[0], 0);
    bad = 0;
    for (int i = 0; i < TRST + 20; i++) begin
      step();
      if (done_w[0] || busy_w[0] || data_w[0]) bad++;
    end
    check("no activity after abort", bad, 0);
    run_single(0);

    // RGBW chain, three LEDs of 0xA5A5A5A5.
    brightness_v = 8'd255;
    for (int i = 0; i < 3; i++) write_px(1, i, 32'hA5A5A5A5);
    run_single(1);
    check("rgbw bit0 high", hi_cnt[0], 11);
    check("rgbw bit1 high", hi_cnt[1], 5);
    check("rgbw bit5 high", hi_cnt[5], 11);
    check("rgbw bit6 high", hi_cnt[6], 5);
    check("rgbw bit32 high", hi_cnt[32], 11);
    check("rgbw bit95 high", hi_cnt[95], 11);
    for (int i = 0; i < 3; i++) write_px(1, i, $urandom);
    write_px(1, 3, $urandom);
    brightness_v = 8'($urandom);
    run_single(1);

    // Free-running chain: frame_done period and next-frame write visibility.
    for (int i = 0; i < 3; i++) write_px(2, i, $urandom);
    brightness_v = 8'($urandom);
    waited = 0;
    while (!done_w[2] && waited < 2 * (TPER * 72 + TRST + 2)) begin
      step();
      waited++;
    end
    check("continuous done seen", done_w[2], 1);
    if (done_w[2]) begin
      for (int f = 0; f < 4; f++) begin
        act_wr_val = $urandom;
        if (f == 0) begin
          act_wr_k    = 2 * 24 * TPER + 7;
          act_wr_addr = 1;
        end else if (f == 1) begin
          act_wr_k    = 30;
          act_wr_addr = 0;
        end else if (f == 2) begin
          act_wr_k    = 500;
          act_wr_addr = 3;
        end
        step();
        expect_frame(2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ws2812_chain_driver.md
Name: ws2812_chain_driver

Overview:
- Parametrised next-generation driver for WS2812/SK6812 addressable LED chains.
- Generalises pixel width (RGB 24-bit or RGBW 32-bit), bit timing in nanoseconds and LED count.
- Adds a global brightness scaler and a triggered-frame mode with start/busy/done handshake, alongside free-running refresh.
- Sits between a pixel-writing host (CPU bus bridge or pattern generator) and a single LED data pin.

Parameters:
- NUM_LEDS, 8, number of LEDs in the chain (>=1).
- BITS_PER_LED, 24, 24 (GRB) or 32 (GRBW); any other value is a compile-time error.
- CLK_MHZ, 12, integer clock frequency in MHz.
- T0H_NS, 350, high time of a 0 bit.
- T1H_NS, 900, high time of a 1 bit.
- PERIOD_NS, 1250, total bit period.
- RESET_US, 280, latch low time after the last bit.
- CONTINUOUS, 1, 1 = auto-refresh forever; 0 = send one frame per start pulse.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write pixel word this cycle
- wr_addr  in  ADDR_W=max(1,$clog2(NUM_LEDS))  pixel index; values >= NUM_LEDS are ignored
- wr_data  in  BITS_PER_LED  pixel word, MSB byte first on the wire
- brightness  in  8  global scale, 255 = full
- start  in  1  frame request pulse (used only when CONTINUOUS=0)
- busy  out  1  high from frame start until latch complete
- frame_done  out  1  one-cycle pulse at the end of each latch period
- data  out  1  registered LED data line

Behaviour:
- Cycle counts use integer ceiling, count = (CLK_MHZ*ns+999)/1000:
  - T_PER = 15, T1H = 11, T0H = 5 at defaults.
  - T_RST = CLK_MHZ*RESET_US = 3360 at defaults.
  - Elaboration check: T0H < T1H < T_PER.
- Reset:
  - data=0, busy=0, frame_done=0.
  - Pixel memory is not cleared, so it infers BRAM.
  - State goes to LATCH with a full T_RST count if CONTINUOUS=1, otherwise to IDLE.
- Pixel memory:
  - 1 write port, 1 read port, 1-cycle read latency.
  - Writes are accepted in any state. A write to the LED currently being shifted takes effect in the next frame.
- States:
  - IDLE: data=0. If start, go to FETCH and set busy=1. start is ignored in every other state.
  - FETCH (2 cycles):
    - Read LED 0.
    - Sample brightness into a register held for the whole frame.
    - Scale each byte: c' = (c*(brightness+1))>>8 (16-bit product). brightness=255 is identity; brightness=0 gives all zero.
    - Load the shift register, then go to SEND.
  - SEND:
    - Each bit lasts exactly T_PER cycles. data=1 for the first T1H (bit 1) or T0H (bit 0) cycles, else 0.
    - Bits go MSB first; LEDs go in order 0..NUM_LEDS-1.
    - The next LED word is prefetched and scaled during the current LED. There is no gap between the last bit of LED n and the first bit of LED n+1.
    - After the final bit of LED NUM_LEDS-1, go to LATCH.
  - LATCH:
    - data=0 for T_RST cycles.
    - On the final cycle, pulse frame_done.
    - Then go to FETCH if CONTINUOUS=1 (busy stays 1), otherwise go to IDLE with busy=0.
- CONTINUOUS=1: busy is held at 1 after the first latch completes; start is ignored.
- Frame length in SEND: exactly NUM_LEDS*BITS_PER_LED*T_PER cycles.
- Reset asserted mid-frame aborts the frame on the next edge: data=0, no frame_done.
- Counter widths: $clog2(max(T_RST,T_PER)+1) bits. Bit index width $clog2(BITS_PER_LED). LED index width ADDR_W.

Decomposition:
- Package ws2812_pkg:
  - state enum (IDLE, FETCH, SEND, LATCH);
  - ns-to-cycles ceiling function;
  - timing-check macros.
- Sub-module ws2812_bright_scale: combinational per-byte scaler, generic in BITS_PER_LED/8 lanes. The top registers its output.

Test Plan:
- Defaults, CONTINUOUS=0, NUM_LEDS=2. Write LED0=0xFF0000, LED1=0x000001, brightness=255, start.
  - Required: 48 bit periods of 15 cycles each.
  - First 8 bits high 11 cycles, next 39 high 5 cycles, last bit high 11 cycles.
  - data low 3360 cycles, then frame_done pulse, then busy=0.
- brightness=127, LED0=0x808080 -> each byte transmitted as 0x40. brightness=0 -> all 24 bits are 0-bits.
- BITS_PER_LED=32, NUM_LEDS=3, LED words 0xA5A5A5A5 -> 96 periods, alternating 1010 0101 pattern, no inter-LED gap.
- start pulsed again while busy -> ignored; exactly one frame_done; second start after done -> second frame.
- CONTINUOUS=1 -> frame_done every 3*24*15+3360+2 cycles. Write LED1 during frame k -> new value appears in frame k+1 only.
- reset asserted at bit 10 of LED0 -> next cycle data=0, busy=0, no frame_done. wr_addr=NUM_LEDS write -> no memory change.
